// File: rtl/rick_pkg.sv
// Shared definitions for the instruction cache.
//   ICACHE_INDEX_BITS : default log2 of line count
//   ADDR_W / WORD_W   : address and instruction word widths
//   icache_state_e    : miss-handling FSM encoding
package rick_pkg;
  localparam int ICACHE_INDEX_BITS = 4;
  localparam int ADDR_W            = 32;
  localparam int WORD_W            = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } icache_state_e;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage: one valid bit, one tag and one word per line.
//   clk_in, rst_in        : clock, synchronous active-low valid clear
//   rd_idx, rd_tag        : lookup address (combinational read)
//   rd_hit, rd_data       : lookup result
//   wr_en, wr_idx, wr_tag,
//   wr_data               : line fill (synchronous write, sets valid)
module icache_array
  import rick_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int TAG_W    = 26
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic                rd_hit,
  output logic [WORD_W-1:0]   rd_data,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [WORD_W-1:0]   wr_data
);
  localparam int LINES = 1 << IDX_BITS;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [WORD_W-1:0] data_q [LINES];
  logic [WORD_W-1:0] data_d [LINES];

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_data;
    end
    // Reset wins over a simultaneous fill.
    if (!rst_in) valid_d = '0;
  end

  always_ff @(posedge clk_in) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end
endmodule

// File: rtl/icache.sv
// Blocking single-outstanding-miss instruction cache.
//   clk_in, rst_in, rdy_in            : clock, sync active-low reset, global stall
//   fetch_req/pc/ready/valid/inst     : fetch unit side
//   flush                             : drops any in-flight response
//   icache_in, icache_address_in,
//   icache_received, icache_task_out,
//   value_load                        : memory controller side
module icache #(
  parameter int ICACHE_INDEX_BITS = rick_pkg::ICACHE_INDEX_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  input  logic        flush,
  output logic        icache_in,
  output logic [31:0] icache_address_in,
  input  logic        icache_received,
  input  logic        icache_task_out,
  input  logic [31:0] value_load
);
  import rick_pkg::*;

  localparam int IB    = ICACHE_INDEX_BITS;
  localparam int TAG_W = ADDR_W - IB - 2;

  icache_state_e     state_q, state_d;
  logic              discard_q, discard_d;
  logic              icache_in_q, icache_in_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [WORD_W-1:0] fetch_inst_q, fetch_inst_d;

  logic              hit;
  logic [WORD_W-1:0] hit_data;
  logic              fill_en;

  assign fetch_ready       = (state_q == ST_IDLE) && !flush;
  assign fetch_valid       = fetch_valid_q;
  assign fetch_inst        = fetch_inst_q;
  assign icache_in         = icache_in_q;
  assign icache_address_in = addr_q;

  // The miss address register doubles as the pending pc for the fill.
  icache_array #(.IDX_BITS(IB), .TAG_W(TAG_W)) u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (fetch_pc[IB+1:2]),
    .rd_tag  (fetch_pc[ADDR_W-1:IB+2]),
    .rd_hit  (hit),
    .rd_data (hit_data),
    .wr_en   (fill_en),
    .wr_idx  (addr_q[IB+1:2]),
    .wr_tag  (addr_q[ADDR_W-1:IB+2]),
    .wr_data (value_load)
  );

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    icache_in_d   = icache_in_q;
    addr_d        = addr_q;
    fetch_valid_d = fetch_valid_q;
    fetch_inst_d  = fetch_inst_q;
    fill_en       = 1'b0;
    // With rdy_in low everything, including a pending pulse, is held.
    if (rdy_in) begin
      fetch_valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          discard_d = 1'b0;
          if (fetch_req && fetch_ready) begin
            if (hit) begin
              fetch_valid_d = 1'b1;
              fetch_inst_d  = hit_data;
            end else begin
              state_d     = ST_REQ;
              icache_in_d = 1'b1;
              addr_d      = {fetch_pc[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_REQ: begin
          if (flush) discard_d = 1'b1;
          if (icache_received) begin
            icache_in_d = 1'b0;
            state_d     = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush) discard_d = 1'b1;
          if (icache_task_out) begin
            // The fill happens even for a flushed miss; only the reply is dropped.
            fill_en   = 1'b1;
            state_d   = ST_IDLE;
            discard_d = 1'b0;
            if (!discard_q && !flush) begin
              fetch_valid_d = 1'b1;
              fetch_inst_d  = value_load;
            end
          end
        end
        default: begin
          state_d     = ST_IDLE;
          icache_in_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      discard_q     <= 1'b0;
      icache_in_q   <= 1'b0;
      addr_q        <= '0;
      fetch_valid_q <= 1'b0;
      fetch_inst_q  <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      icache_in_q   <= icache_in_d;
      addr_q        <= addr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_inst_q  <= fetch_inst_d;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: expected fetch words are queued when a fetch
// or fill is driven and popped by a monitor whenever fetch_valid appears.
module tb_icache;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, fetch_req, flush;
  logic [31:0] fetch_pc, value_load;
  logic        icache_received, icache_task_out;
  logic        fetch_ready, fetch_valid, icache_in;
  logic [31:0] fetch_inst, icache_address_in;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_inst = 32'h0;

  icache dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .fetch_req         (fetch_req),
    .fetch_pc          (fetch_pc),
    .fetch_ready       (fetch_ready),
    .fetch_valid       (fetch_valid),
    .fetch_inst        (fetch_inst),
    .flush             (flush),
    .icache_in         (icache_in),
    .icache_address_in (icache_address_in),
    .icache_received   (icache_received),
    .icache_task_out   (icache_task_out),
    .value_load        (value_load)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard monitor: every fetch_valid pulse must match the queue head.
  always @(negedge clk_in) begin
    if (fetch_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL sb_unexpected obs=%h exp=<none>", fetch_inst);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        assert (fetch_inst === e) else begin
          failures++;
          $error("FAIL sb_inst obs=%h exp=%h", fetch_inst, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // flush_mode: 0 none, 1 flush in WAIT before the reply, 2 flush with the reply
  task automatic miss(input logic [31:0] pc, input logic [31:0] word,
                      input int lat, input int flush_mode);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    fetch_req = 1'b1; fetch_pc = pc;
    cyc();
    fetch_req = 1'b0;
    check("miss_req", icache_in, 1);
    check("miss_addr", icache_address_in, a);
    check("miss_busy", fetch_ready, 0);
    repeat (lat) begin
      cyc();
      check("req_hold", icache_in, 1);
    end
    icache_received = 1'b1;
    cyc();
    icache_received = 1'b0;
    check("req_drop", icache_in, 0);
    if (flush_mode == 1) flush = 1'b1;
    cyc();
    flush = 1'b0;
    icache_task_out = 1'b1; value_load = word;
    if (flush_mode == 2) flush = 1'b1;
    if (flush_mode == 0) begin exp_q.push_back(word); last_inst = word; end
    cyc();
    icache_task_out = 1'b0; flush = 1'b0;
    check("fill_valid", fetch_valid, (flush_mode == 0) ? 32'd1 : 32'd0);
    check("fill_inst", fetch_inst, last_inst);
    cyc();
    check("pulse_end", fetch_valid, 0);
    check("idle_no_req", icache_in, 0);
  endtask

  task automatic hit(input logic [31:0] pc, input logic [31:0] word);
    fetch_req = 1'b1; fetch_pc = pc;
    exp_q.push_back(word); last_inst = word;
    cyc();
    fetch_req = 1'b0;
    check("hit_valid", fetch_valid, 1);
    check("hit_inst", fetch_inst, word);
    check("hit_no_req", icache_in, 0);
    check("hit_ready", fetch_ready, 1);
    cyc();
    check("hit_pulse_end", fetch_valid, 0);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; fetch_req = 1'b0; flush = 1'b0;
    fetch_pc = '0; value_load = '0; icache_received = 1'b0; icache_task_out = 1'b0;
    cyc(); cyc();
    check("rst_icache_in", icache_in, 0);
    check("rst_addr", icache_address_in, 0);
    check("rst_valid", fetch_valid, 0);
    check("rst_inst", fetch_inst, 0);
    rst_in = 1'b1;
    cyc();
    check("rst_ready", fetch_ready, 1);

    // Cold miss, then hit.
    miss(32'h0000_0000, 32'h0000_0013, 2, 0);
    hit(32'h0000_0000, 32'h0000_0013);
    hit(32'h0000_0002, 32'h0000_0013);  // byte offset ignored

    // Conflict on index 0.
    miss(32'h0000_0040, 32'hFE01_0113, 1, 0);
    miss(32'h0000_0000, 32'h0000_0013, 0, 0);
    hit(32'h0000_0000, 32'h0000_0013);

    // Flush while waiting: line filled, reply dropped.
    miss(32'h0000_0008, 32'hDEAD_BEEF, 1, 1);
    hit(32'h0000_0008, 32'hDEAD_BEEF);

    // Flush in IDLE blocks both a hit and a miss.
    flush = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h0000_0000;
    #1;
    check("flush_ready", fetch_ready, 0);
    cyc();
    check("flush_hit_blocked", fetch_valid, 0);
    fetch_pc = 32'h0000_0100;
    cyc();
    check("flush_miss_blocked", icache_in, 0);
    flush = 1'b0; fetch_req = 1'b0;
    cyc();

    // Flush coincident with the reply.
    miss(32'h0000_000C, 32'h1234_5678, 0, 2);
    hit(32'h0000_000C, 32'h1234_5678);

    // Stall in WAIT.
    fetch_req = 1'b1; fetch_pc = 32'h0000_0010;
    cyc();
    fetch_req = 1'b0;
    icache_received = 1'b1;
    cyc();
    icache_received = 1'b0;
    rdy_in = 1'b0;
    value_load = 32'hA5A5_0001;
    repeat (3) begin
      cyc();
      check("stall_req", icache_in, 0);
      check("stall_valid", fetch_valid, 0);
      check("stall_inst", fetch_inst, last_inst);
      check("stall_busy", fetch_ready, 0);
      check("stall_addr", icache_address_in, 32'h0000_0010);
    end
    icache_task_out = 1'b1;
    cyc();
    check("stall_task_ignored", fetch_valid, 0);
    rdy_in = 1'b1;
    exp_q.push_back(32'hA5A5_0001); last_inst = 32'hA5A5_0001;
    cyc();
    icache_task_out = 1'b0;
    check("stall_done_valid", fetch_valid, 1);
    check("stall_done_inst", fetch_inst, 32'hA5A5_0001);
    cyc();
    hit(32'h0000_0010, 32'hA5A5_0001);

    // Reset during REQ abandons the miss and clears the array.
    fetch_req = 1'b1; fetch_pc = 32'h0000_0014;
    cyc();
    fetch_req = 1'b0;
    check("pre_rst_req", icache_in, 1);
    rst_in = 1'b0;
    cyc();
    rst_in = 1'b1;
    check("midrst_req", icache_in, 0);
    check("midrst_addr", icache_address_in, 0);
    check("midrst_valid", fetch_valid, 0);
    check("midrst_inst", fetch_inst, 0);
    last_inst = 32'h0;
    cyc();
    miss(32'h0000_0008, 32'hCAFE_F00D, 0, 0);

    repeat (2) cyc();
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter: ICACHE_INDEX_BITS, default 4, log2 of line count (16 one-word lines).
REQ-003 clk_in  input  1  clock, all state updates on its rising edge.
REQ-004 rst_in  input  1  synchronous reset, active-low (0 = reset).
REQ-005 rdy_in  input  1  global ready; 0 freezes all state and outputs.
REQ-006 fetch_req  input  1  fetch unit requests one instruction.
REQ-007 fetch_pc  input  32  fetch byte address; bits [1:0] ignored.
REQ-008 fetch_ready  output  1  high when a fetch_req will be accepted this cycle.
REQ-009 fetch_valid  output  1  one-cycle pulse: fetch_inst is valid.
REQ-010 fetch_inst  output  32  returned instruction word.
REQ-011 flush  input  1  misprediction flush from the ROB; discards any outstanding response.
REQ-012 icache_in  output  1  request to the memory controller.
REQ-013 icache_address_in  output  32  word address sent to the memory controller, bits [1:0] = 0.
REQ-014 icache_received  input  1  one-cycle pulse: the memory controller accepted the request.
REQ-015 icache_task_out  input  1  one-cycle pulse: value_load holds the fetched word.
REQ-016 value_load  input  32  little-endian word from the memory controller.

Function
REQ-017 Direct-mapped organisation: index = pc[ICACHE_INDEX_BITS+1:2]; tag = pc[31:ICACHE_INDEX_BITS+2]; each line holds one valid bit, one tag and one 32-bit word.
REQ-018 States: IDLE, REQ, WAIT; fetch_ready = (state == IDLE) && !flush.
REQ-019 A fetch is accepted when fetch_req && fetch_ready && rdy_in; while fetch_ready is low, fetch_req is ignored.
REQ-020 Hit (valid && tag match): fetch_valid = 1 and fetch_inst = line data at the next edge; state stays IDLE (1-cycle latency).
REQ-021 Miss: at the next edge, state goes to REQ, icache_in = 1, icache_address_in = {pc[31:2], 2'b00}, and the pending pc is latched.
REQ-022 REQ: icache_in stays 1 until icache_received = 1 is sampled; at that edge icache_in goes to 0 and state goes to WAIT.
REQ-023 icache_in SHALL be 0 in every state except REQ, so the controller never serves a second request.
REQ-024 WAIT: when icache_task_out = 1 is sampled, the line is written with value_load and the latched tag with valid = 1, and state goes to IDLE.
REQ-025 In the same WAIT edge, fetch_valid = 1 and fetch_inst = value_load unless the response is discarded.
REQ-026 fetch_valid is a single-cycle pulse; fetch_inst holds its last value otherwise.
REQ-027 Flush in IDLE: the same-cycle request, hit or miss, is not accepted and produces no fetch_valid.
REQ-028 Flush in REQ or WAIT: set the discard flag. The memory transaction still completes (it cannot be aborted), the line is still filled, fetch_valid stays 0, and the flag is cleared on return to IDLE.
REQ-029 Flush in the same cycle as icache_task_out: fill the line, suppress fetch_valid.
REQ-030 rdy_in = 0: no state, array or output changes; pulses are not regenerated or lost, and are re-evaluated when rdy_in returns.

Reset
REQ-031 rst_in = 0 at a clock edge SHALL force: state = IDLE; all valid bits = 0; discard flag = 0; icache_in = 0; icache_address_in = 0; fetch_valid = 0; fetch_inst = 0.
REQ-032 Reset mid-miss abandons the transaction with no fill and no fetch_valid. Reset takes priority over rdy_in.

Structure
REQ-033 The shared package rick_pkg SHALL hold ICACHE_INDEX_BITS, the IDLE/REQ/WAIT state encoding and the 32-bit address/word width constants.
REQ-034 Sub-module icache_array SHALL hold the valid/tag/data storage (combinational read, synchronous write, synchronous valid clear). The icache top contains only the FSM and handshake.

Verification
REQ-035 Cold miss at pc 0x00000000, memory model returns 0x00000013 -> icache_in = 1 until received, icache_address_in = 0x00000000, fetch_valid pulse with 0x00000013 one edge after task_out.
REQ-036 Repeat fetch at 0x00000000 -> fetch_valid next cycle with 0x00000013, icache_in stays 0.
REQ-037 Fetch 0x00000040 (index 0, new tag), model returns 0xFE010113 -> miss and fill; refetch 0x00000000 misses again.
REQ-038 Flush one cycle after icache_received on a miss at 0x00000008 -> no fetch_valid; later fetch of 0x00000008 hits with the filled word.
REQ-039 rdy_in = 0 for 3 cycles in WAIT with task_out held off -> outputs and state unchanged; completes normally afterwards.
REQ-040 rst_in = 0 during REQ -> icache_in = 0 next edge; fetch of a previously cached pc misses.
